// File: rtl/cover_toggle_drain.sv
// cover_toggle_drain
//   Consuming end of a per-bit toggle cover interface. Samples a WIDTH-bit
//   strobe vector every cycle, keeps a sticky hit bitmap, and reports each
//   newly hit point exactly once as a global cover index on a valid/ready
//   stream, lowest pending bit first.
//
// Ports
//   clock      sole clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   enable     when low, valid is ignored (draining continues)
//   valid      per-point hit strobes
//   clear      synchronous clear of bitmap, pending set and count
//   out_valid  a pending newly-hit index is presented
//   out_ready  consumer accepts out_index this cycle
//   out_index  COVER_INDEX + lowest pending bit position
//   hit_count  distinct points hit since reset/clear
//   all_hit    every point has been hit
//   drained    all_hit and nothing left to report
module cover_toggle_drain #(
    parameter int unsigned WIDTH       = 35,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = 8744,
    parameter int unsigned IDX_W       = 32,
    parameter int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] valid,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [CNT_W-1:0] hit_count,
    output logic             all_hit,
    output logic             drained
);

    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
        $error("cover_toggle_drain: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0] hit_map_q, hit_map_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] grant;
    logic [WIDTH-1:0] low_onehot;
    logic [IDX_W-1:0] low_idx;
    logic             low_found;
    logic [CNT_W-1:0] new_count;

    // Lowest set pending bit: position and one-hot.
    always_comb begin
        low_idx    = '0;
        low_onehot = '0;
        low_found  = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pending_q[i] && !low_found) begin
                low_found     = 1'b1;
                low_idx       = IDX_W'(i);
                low_onehot[i] = 1'b1;
            end
        end
    end

    // New hits are disjoint from hit_map, so the count can never pass WIDTH.
    always_comb begin
        new_hits  = valid & ~hit_map_q & {WIDTH{enable}};
        new_count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            new_count = new_count + CNT_W'(new_hits[i]);
        end
    end

    always_comb begin
        grant = (low_found && out_ready) ? low_onehot : '0;
        if (clear) begin
            hit_map_d   = '0;
            pending_d   = '0;
            hit_count_d = '0;
        end else begin
            hit_map_d   = hit_map_q | new_hits;
            pending_d   = (pending_q & ~grant) | new_hits;
            hit_count_d = hit_count_q + new_count;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_map_q   <= '0;
            pending_q   <= '0;
            hit_count_q <= '0;
        end else begin
            hit_map_q   <= hit_map_d;
            pending_q   <= pending_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign out_valid = |pending_q;
    assign out_index = IDX_W'(COVER_INDEX) + low_idx;
    assign hit_count = hit_count_q;
    assign all_hit   = (hit_count_q == CNT_W'(WIDTH));
    assign drained   = all_hit && !out_valid;

endmodule

// File: tb/tb_cover_toggle_drain.sv
module tb_cover_toggle_drain;

    localparam int W  = 35;
    localparam int CI = 100;
    localparam int CW = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [W-1:0]  valid = '0;
    logic          clear = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [31:0]   out_index;
    logic [CW-1:0] hit_count;
    logic          all_hit;
    logic          drained;

    cover_toggle_drain #(
        .WIDTH(W),
        .COVER_INDEX(CI),
        .COVER_TOTAL(8744),
        .IDX_W(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .valid(valid),
        .clear(clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .hit_count(hit_count),
        .all_hit(all_hit),
        .drained(drained)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: set of hit points, set of points awaiting report.
    bit m_hit[W];
    bit m_pend[W];
    int m_cnt;
    int log_q[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_hit[i]  = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    function automatic int m_low();
        for (int i = 0; i < W; i++)
            if (m_pend[i]) return i;
        return -1;
    endfunction

    function automatic logic [W-1:0] bitv(int i);
        logic [W-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic check_outputs();
        int low;
        low = m_low();
        chk("out_valid", out_valid, (low >= 0));
        if (low >= 0) chk("out_index", out_index, CI + low);
        chk("hit_count", hit_count, m_cnt);
        chk("all_hit", all_hit, (m_cnt == W));
        chk("drained", drained, (m_cnt == W) && (low < 0));
    endtask

    // One clock cycle: drive, check current outputs, advance model, clock.
    task automatic cyc(logic [W-1:0] v, bit e, bit c, bit r);
        int low;
        valid = v; enable = e; clear = c; out_ready = r;
        #1;
        check_outputs();
        if (out_valid && r) log_q.push_back(int'(out_index));
        low = m_low();
        if (r && low >= 0) m_pend[low] = 1'b0;
        if (c) begin
            model_reset();
        end else if (e) begin
            for (int i = 0; i < W; i++) begin
                if (v[i] && !m_hit[i]) begin
                    m_hit[i]  = 1'b1;
                    m_pend[i] = 1'b1;
                    m_cnt++;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_index", out_index, CI);
        chk("arst_hit_count", hit_count, 0);
        chk("arst_all_hit", all_hit, 0);
        chk("arst_drained", drained, 0);
        model_reset();
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rv;
        model_reset();

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, CI);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_all_hit", all_hit, 0);
        chk("rst_drained", drained, 0);
        #10 reset = 1'b0;
        @(posedge clock);
        #1;

        // Idle
        for (int k = 0; k < 10; k++) cyc('0, 1, 0, 1'($urandom_range(1)));

        // Two hits drain lowest first
        log_q.delete();
        cyc(bitv(5) | bitv(2), 1, 0, 1);
        for (int k = 0; k < 3; k++) cyc('0, 1, 0, 1);
        chk("pair_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("pair_0", log_q[0], 102);
            chk("pair_1", log_q[1], 105);
        end

        // Held strobe while stalled: reported once
        log_q.delete();
        for (int k = 0; k < 20; k++) cyc(bitv(7), 1, 0, k >= 6);
        chk("held_n", log_q.size(), 1);
        if (log_q.size() == 1) chk("held_0", log_q[0], 107);

        // Lower index overtakes a stalled one
        cyc('0, 1, 1, 0);
        cyc(bitv(10), 1, 0, 0);
        for (int k = 0; k < 3; k++) cyc('0, 1, 0, 0);
        cyc(bitv(3), 1, 0, 0);
        chk("switch_idx", out_index, CI + 3);
        cyc('0, 1, 0, 0);
        log_q.delete();
        for (int k = 0; k < 3; k++) cyc('0, 1, 0, 1);
        chk("switch_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("switch_0", log_q[0], 103);
            chk("switch_1", log_q[1], 110);
        end

        // Clear discards same-cycle valid; re-hit reported again
        cyc(bitv(1), 1, 1, 1);
        chk("clr_hit_count", hit_count, 0);
        chk("clr_out_valid", out_valid, 0);
        log_q.delete();
        cyc(bitv(1), 1, 0, 1);
        cyc('0, 1, 0, 1);
        cyc('0, 1, 0, 1);
        chk("rehit_n", log_q.size(), 1);
        if (log_q.size() == 1) chk("rehit_0", log_q[0], 101);

        // All points at once: 35 ordered handshakes
        cyc('0, 1, 1, 0);
        log_q.delete();
        cyc('1, 1, 0, 1);
        for (int k = 0; k < W + 1; k++) cyc('0, 1, 0, 1);
        chk("all_n", log_q.size(), W);
        for (int k = 0; k < log_q.size(); k++) chk("all_seq", log_q[k], CI + k);
        chk("all_hit_end", all_hit, 1);
        chk("drained_end", drained, 1);

        // enable low ignores strobes
        cyc('0, 1, 1, 0);
        for (int k = 0; k < 3; k++) cyc('1, 0, 0, 1);
        chk("dis_hit_count", hit_count, 0);

        // Async reset mid-drain
        cyc('1, 1, 0, 1);
        for (int k = 0; k < 5; k++) cyc('0, 1, 0, 1);
        async_reset_pulse();
        for (int k = 0; k < 3; k++) cyc('0, 1, 0, 1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < W; i++) rv[i] = ($urandom_range(15) == 0);
            cyc(rv, $urandom_range(3) != 0, $urandom_range(99) == 0,
                1'($urandom_range(1)));
            if ($urandom_range(249) == 0) async_reset_pulse();
        end
        for (int k = 0; k < W + 2; k++) cyc('0, 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
